softmax_vec_packer: RTL

Element-to-vector packer that drives the wide input port of the `softmax` block. It accepts a narrow stream of signed 8-bit logits, one per beat, and assembles NUM_ELEM of them into one VEC_W-bit vector. It presents that vector on a valid/ready handshake that matches `s_axis_softmax_data` / `tvalid` / `tready`. A one-vector output register lets the next vector assemble while the current one waits for `softmax`.

---
 rtl/softmax_vec_packer.sv | 69 ++++++
 1 files changed

// File: rtl/softmax_vec_packer.sv
// softmax_vec_packer: packs signed ELEM_W-bit logits into NUM_ELEM-lane vectors for the softmax input port.
// Define PACKER_PAD_EN to emit short vectors padded with the most-negative value instead of discarding them.
module softmax_vec_packer #(
  parameter int ELEM_W   = 8,
  parameter int NUM_ELEM = 65,
  parameter int VEC_W    = ELEM_W*NUM_ELEM,
  parameter int CNT_W    = $clog2(NUM_ELEM)
) (
  input  logic              aclk,
  input  logic              rst_n,
  input  logic [ELEM_W-1:0] s_axis_elem_tdata,
  input  logic              s_axis_elem_tvalid,
  input  logic              s_axis_elem_tlast,
  output logic              s_axis_elem_tready,
  output logic [VEC_W-1:0]  m_axis_softmax_data,
  output logic              m_axis_softmax_tvalid,
  input  logic              m_axis_softmax_tready,
  output logic              err_len
);
  typedef enum logic {FILL, HOLD} state_e;
  localparam logic [ELEM_W-1:0] PAD_VAL = {1'b1, {(ELEM_W-1){1'b0}}};
  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [VEC_W-1:0] asm_q, data_q, vec_d;
  logic             tvalid_q, err_q;
  logic             acc, last_lane, close, pad, drop, slot_free, load;
  always_comb begin
    acc       = s_axis_elem_tvalid && state_q == FILL;
    last_lane = cnt_q == CNT_W'(NUM_ELEM-1);
    slot_free = !tvalid_q || m_axis_softmax_tready;
`ifdef PACKER_PAD_EN
    close     = acc && (last_lane || s_axis_elem_tlast);
    pad       = close && !last_lane;
    drop      = 1'b0;
`else
    close     = acc && last_lane;
    pad       = 1'b0;
    drop      = acc && s_axis_elem_tlast && !last_lane;
`endif
    load      = slot_free && (close || state_q == HOLD);
  end
  // The vector seen at the accepting edge already contains the incoming lane (and padding above it).
  for (genvar g = 0; g < NUM_ELEM; g++) begin : g_lane
    assign vec_d[g*ELEM_W +: ELEM_W] = CNT_W'(g) == cnt_q ? s_axis_elem_tdata :
                                       pad && CNT_W'(g) > cnt_q ? PAD_VAL :
                                       asm_q[g*ELEM_W +: ELEM_W];
  end
  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= FILL;
      cnt_q    <= '0;
      asm_q    <= '0;
      data_q   <= '0;
      tvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (acc) asm_q <= vec_d;
      if (load) data_q <= state_q == HOLD ? asm_q : vec_d;
      tvalid_q <= load || (tvalid_q && !m_axis_softmax_tready);
      cnt_q    <= (close || drop) ? '0 : acc ? cnt_q + 1'b1 : cnt_q;
      state_q  <= close && !slot_free ? HOLD : (state_q == HOLD && slot_free) ? FILL : state_q;
      err_q    <= acc && (s_axis_elem_tlast != last_lane);
    end
  end
  assign s_axis_elem_tready    = state_q == FILL;
  assign m_axis_softmax_data   = data_q;
  assign m_axis_softmax_tvalid = tvalid_q;
  assign err_len               = err_q;
endmodule
